mul_acc_stage: RTL

- Downstream consumer of the n-bit multiplier product stream. Sums a group of WIDTH-bit products into an ACC_WIDTH-bit accumulator, which makes the multiplier a multiply-accumulate datapath.
- Uses a valid/ready handshake on both sides.
- A group closes on in_last or after MAX_LEN beats. The closed group's sum, beat count and overflow flag are then presented as one output transaction.

---
 rtl/mul_acc_if.sv | 27 ++
 rtl/mul_acc_stage.sv | 96 +++++++++
 2 files changed

// File: rtl/mul_acc_if.sv
// Handshake bundle between a product source and mul_acc_stage: the product
// input stream plus the group-result output.
interface mul_acc_if #(
    parameter int WIDTH     = 1,
    parameter int ACC_WIDTH = 8,
    parameter int CNT_WIDTH = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_prod;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_sum;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_ovf;

    modport master (
        output in_valid, in_prod, in_last, out_ready,
        input  in_ready, out_valid, out_sum, out_count, out_ovf
    );

    modport slave (
        input  in_valid, in_prod, in_last, out_ready,
        output in_ready, out_valid, out_sum, out_count, out_ovf
    );
endinterface

// File: rtl/mul_acc_stage.sv
// Sums groups of unsigned products into a wide accumulator; a group closes on
// in_last or after MAX_LEN beats and its sum/count/overflow are held until taken.
module mul_acc_stage #(
    parameter int WIDTH     = 1,
    parameter int ACC_WIDTH = 8,
    parameter int MAX_LEN   = 16,
    parameter int CNT_WIDTH = $clog2(MAX_LEN + 1)
) (
    input  logic      clk,
    input  logic      rst_n,
    mul_acc_if.slave  bus
);
    generate
        if (WIDTH > ACC_WIDTH || MAX_LEN < 1) begin : g_bad_params
            $error("mul_acc_stage: need WIDTH <= ACC_WIDTH and MAX_LEN >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t               r_state;
    logic [ACC_WIDTH-1:0] r_acc;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_ovf;
    logic                 r_out_valid;
    logic [ACC_WIDTH-1:0] r_out_sum;
    logic [CNT_WIDTH-1:0] r_out_cnt;
    logic                 r_out_ovf;

    logic                 w_in_ready;
    logic                 w_accept;
    logic [ACC_WIDTH:0]   w_sum_ext;
    logic [CNT_WIDTH-1:0] w_cnt_next;
    logic                 w_ovf_next;
    logic                 w_close;

    // Ready depends on state only, so the upstream never sees a valid->ready path.
    assign w_in_ready = (r_state != HOLD);
    assign w_accept   = bus.in_valid && w_in_ready;

    // One extra bit captures the carry out of the accumulator.
    assign w_sum_ext  = {1'b0, r_acc} + (ACC_WIDTH + 1)'(bus.in_prod);
    assign w_cnt_next = r_cnt + CNT_WIDTH'(1);
    assign w_ovf_next = r_ovf | w_sum_ext[ACC_WIDTH];
    assign w_close    = bus.in_last || (w_cnt_next == CNT_WIDTH'(MAX_LEN));

    // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_ovf       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_cnt   <= '0;
            r_out_ovf   <= 1'b0;
        end else begin
            case (r_state)
                IDLE, ACCUM: begin
                    if (w_accept) begin
                        if (w_close) begin
                            r_out_sum   <= w_sum_ext[ACC_WIDTH-1:0];
                            r_out_cnt   <= w_cnt_next;
                            r_out_ovf   <= w_ovf_next;
                            r_out_valid <= 1'b1;
                            r_state     <= HOLD;
                        end else begin
                            r_acc   <= w_sum_ext[ACC_WIDTH-1:0];
                            r_cnt   <= w_cnt_next;
                            r_ovf   <= w_ovf_next;
                            r_state <= ACCUM;
                        end
                    end
                end
                HOLD: begin
                    // Result registers are left as-is so they stay readable after the handshake.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_cnt       <= '0;
                        r_ovf       <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_sum   = r_out_sum;
    assign bus.out_count = r_out_cnt;
    assign bus.out_ovf   = r_out_ovf;
endmodule
